// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier datapath.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP    = 2'd0,
        MULH_OP   = 2'd1,
        MULHSU_OP = 2'd2,
        MULHU_OP  = 2'd3
    } mul_op_e;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic int pp_num(input int width);
        return (width / 2) + 1;
    endfunction

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Recodes {b[2i+1], b[2i], b[2i-1]} into a digit in {-2..+2}; both zero codes yield neg=0
    function automatic booth_digit_t booth_encode(input logic [2:0] trip);
        booth_digit_t dig;
        case (trip)
            3'b001, 3'b010: dig = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b011:         dig = '{neg: 1'b0, one: 1'b0, two: 1'b1};
            3'b100:         dig = '{neg: 1'b1, one: 1'b0, two: 1'b1};
            3'b101, 3'b110: dig = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            default:        dig = '{neg: 1'b0, one: 1'b0, two: 1'b0};
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/csa_compress_tree.sv
// Generic Wallace-style carry-save tree: reduces ROWS addends of ROW_W bits to a sum/carry pair
// using layers of 3:2 compressors. Purely combinational; results are modulo 2^ROW_W.
module csa_compress_tree #(
    parameter int ROWS  = 4,
    parameter int ROW_W = 16
) (
    input  logic [ROWS-1:0][ROW_W-1:0] rows,
    output logic [ROW_W-1:0]           sum,
    output logic [ROW_W-1:0]           carry
);

    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int k = 0; k < lvl; k++) begin
            r = next_rows(r);
        end
        return r;
    endfunction

    function automatic int num_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = next_rows(r);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels(ROWS);

    logic [ROW_W-1:0] tree_s [LEVELS+1][ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_in
        assign tree_s[0][r] = rows[r];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = rows_at(ROWS, l);
        localparam int G = N / 3;

        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [ROW_W-1:0] x_s, y_s, z_s;
            assign x_s = tree_s[l][3*g];
            assign y_s = tree_s[l][3*g+1];
            assign z_s = tree_s[l][3*g+2];
            assign tree_s[l+1][2*g]   = x_s ^ y_s ^ z_s;
            assign tree_s[l+1][2*g+1] = ((x_s & y_s) | (x_s & z_s) | (y_s & z_s)) << 1;
        end

        // Leftover rows that do not fill a compressor pass straight to the next layer
        for (genvar p = 3*G; p < N; p++) begin : g_pass
            assign tree_s[l+1][p-G] = tree_s[l][p];
        end

        for (genvar t = N-G; t < ROWS; t++) begin : g_tie
            assign tree_s[l+1][t] = '0;
        end
    end

    assign sum   = tree_s[LEVELS][0];
    assign carry = tree_s[LEVELS][1];

endmodule

// File: rtl/booth_wallace_multiplier.sv
// 3-stage radix-4 Booth / carry-save multiplier for MUL, MULH, MULHSU and MULHU with valid/ready,
// flush and tag passthrough. Define MUL_PERF_CNT_EN to add the accepted-op counter perf_mul_cnt_o.
module booth_wallace_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     result_o,
    output logic [TAG_WIDTH-1:0] tag_o
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_mul_cnt_o
`endif
);

    localparam int PP_NUM = pp_num(WIDTH);
    localparam int PROD_W = prod_w(WIDTH);
    localparam int EXT_W  = WIDTH + 2;
    localparam int ROWS   = PP_NUM + 2;

    // Rows are stored as {~sign, low bits}; this constant subtracts the 2^(EXT_W+2i) bias of every row
    function automatic logic [PROD_W-1:0] se_const();
        logic [PROD_W-1:0] c;
        c = '0;
        for (int i = 0; i < PP_NUM; i++) begin
            c = c - ({{(PROD_W-1){1'b0}}, 1'b1} << (EXT_W + 2*i));
        end
        return c;
    endfunction

    localparam logic [PROD_W-1:0] SE_CONST = se_const();

    // One partial product: {neg, (digit magnitude * a) in EXT_W+1 bits, ones-complemented when negative}
    function automatic logic [EXT_W+1:0] booth_row(input logic [EXT_W-1:0] a_ext, input logic [2:0] trip);
        booth_digit_t     dig;
        logic [EXT_W:0]   mag;
        dig = booth_encode(trip);
        if (dig.two) begin
            mag = {a_ext, 1'b0};
        end else if (dig.one) begin
            mag = {a_ext[EXT_W-1], a_ext};
        end else begin
            mag = '0;
        end
        return {dig.neg, mag ^ {(EXT_W+1){dig.neg}}};
    endfunction

    logic adv0_s, adv1_s, adv2_s, accept_s;
    logic v0_r, v1_r;

    mul_op_e                        op_s;
    logic [EXT_W-1:0]               a_ext_s, b_ext_s;
    logic [EXT_W:0]                 b_pad_s;
    logic [PP_NUM-1:0][EXT_W:0]     pp_s;
    logic [PP_NUM-1:0]              neg_s;

    logic [PP_NUM-1:0][EXT_W:0]     pp0_r;
    logic [PP_NUM-1:0]              neg0_r;
    mul_op_e                        op0_r;
    logic [TAG_WIDTH-1:0]           tag0_r;

    logic [ROWS-1:0][PROD_W-1:0]    rows_s;
    logic [PROD_W-1:0]              csa_sum_s, csa_carry_s;

    logic [PROD_W-1:0]              sum1_r, carry1_r;
    mul_op_e                        op1_r;
    logic [TAG_WIDTH-1:0]           tag1_r;

    logic [PROD_W-1:0]              prod_s;
    logic [WIDTH-1:0]               res_s;

    assign adv2_s     = !out_valid_o || out_ready_i;
    assign adv1_s     = !v1_r || adv2_s;
    assign adv0_s     = !v0_r || adv1_s;
    assign in_ready_o = adv0_s;
    assign accept_s   = in_valid_i && in_ready_o && !flush_i;

    // S0: operand extension and Booth partial-product generation
    always_comb begin
        op_s    = mul_op_e'(op_i);
        a_ext_s = (op_s == MULHU_OP) ? {2'b00, a_i} : {{2{a_i[WIDTH-1]}}, a_i};
        b_ext_s = (op_s == MUL_OP || op_s == MULH_OP) ? {{2{b_i[WIDTH-1]}}, b_i} : {2'b00, b_i};
        b_pad_s = {b_ext_s, 1'b0};
        pp_s    = '0;
        neg_s   = '0;
        for (int i = 0; i < PP_NUM; i++) begin
            {neg_s[i], pp_s[i]} = booth_row(a_ext_s, b_pad_s[2*i +: 3]);
        end
    end

    // Stage valid bits: shift on advance, cleared by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_r        <= 1'b0;
            v1_r        <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            v0_r        <= 1'b0;
            v1_r        <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (adv0_s) v0_r        <= in_valid_i;
            if (adv1_s) v1_r        <= v0_r;
            if (adv2_s) out_valid_o <= v1_r;
        end
    end

    // reg0: partial products, loaded only on an accepted op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp0_r  <= '0;
            neg0_r <= '0;
            op0_r  <= MUL_OP;
            tag0_r <= '0;
        end else if (accept_s) begin
            pp0_r  <= pp_s;
            neg0_r <= neg_s;
            op0_r  <= op_s;
            tag0_r <= tag_i;
        end
    end

    // S1: place rows at their radix-4 weights, plus the negate-bit row and the sign-bias constant
    always_comb begin
        rows_s = '0;
        for (int i = 0; i < PP_NUM; i++) begin
            rows_s[i] = {{(PROD_W-EXT_W-1){1'b0}}, ~pp0_r[i][EXT_W], pp0_r[i][EXT_W-1:0]} << (2*i);
            rows_s[PP_NUM][2*i] = neg0_r[i];
        end
        rows_s[PP_NUM+1] = SE_CONST;
    end

    csa_compress_tree #(
        .ROWS  (ROWS),
        .ROW_W (PROD_W)
    ) u_csa (
        .rows  (rows_s),
        .sum   (csa_sum_s),
        .carry (csa_carry_s)
    );

    // reg1: carry-save pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum1_r   <= '0;
            carry1_r <= '0;
            op1_r    <= MUL_OP;
            tag1_r   <= '0;
        end else if (adv1_s && v0_r && !flush_i) begin
            sum1_r   <= csa_sum_s;
            carry1_r <= csa_carry_s;
            op1_r    <= op0_r;
            tag1_r   <= tag0_r;
        end
    end

    // S2: carry-propagate add and half select
    always_comb begin
        prod_s = sum1_r + carry1_r;
        if (op1_r == MUL_OP) begin
            res_s = prod_s[WIDTH-1:0];
        end else begin
            res_s = prod_s[PROD_W-1:WIDTH];
        end
    end

    // reg2: output register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_o <= '0;
            tag_o    <= '0;
        end else if (adv2_s && v1_r && !flush_i) begin
            result_o <= res_s;
            tag_o    <= tag1_r;
        end
    end

`ifdef MUL_PERF_CNT_EN
    // Accepted-op counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mul_cnt_o <= 32'd0;
        end else if (accept_s) begin
            perf_mul_cnt_o <= perf_mul_cnt_o + 32'd1;
        end
    end
`else
    // Counter absent: accepted ops are not tracked.
`endif

endmodule

// File: tb/tb_booth_wallace_multiplier.sv
// Self-checking bench for booth_wallace_multiplier: directed cases, random stream, stall, flush, reset.
module tb_booth_wallace_multiplier;

    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush_i = 1'b0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic [1:0]           op_i = 2'd0;
    logic [WIDTH-1:0]     a_i = '0;
    logic [WIDTH-1:0]     b_i = '0;
    logic [TAG_WIDTH-1:0] tag_i = '0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic [WIDTH-1:0]     result_o;
    logic [TAG_WIDTH-1:0] tag_o;
`ifdef MUL_PERF_CNT_EN
    logic [31:0]          perf_mul_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [WIDTH+TAG_WIDTH-1:0] exp_q [$];

    booth_wallace_multiplier #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
`ifdef MUL_PERF_CNT_EN
        ,
        .perf_mul_cnt_o (perf_mul_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference: exact 64-bit product with RISC-V signedness, then select the half
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sp;
        logic [63:0] p;
        case (op)
            2'd1: begin sp = longint'(int'(a)) * longint'(int'(b)); p = sp; end
            2'd2: begin sp = longint'(int'(a)) * longint'({32'd0, b}); p = sp; end
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Scoreboard: in-order expected results of accepted, non-flushed ops
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid_o && out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush_i) exp_q.delete();
            else if (in_valid_i && in_ready_o) exp_q.push_back({ref_mul(op_i, a_i, b_i), tag_i});
        end
    end

    task automatic drive_random(input logic [TAG_WIDTH-1:0] tag);
        in_valid_i = 1'b1;
        op_i  = 2'($urandom_range(3, 0));
        a_i   = ($urandom_range(4, 0) == 0) ? 32'h8000_0000 : $urandom;
        b_i   = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
        tag_i = tag;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
        checks++; if (tag_o !== 6'd0) begin failures++; $display("FAIL reset_tag got=%h exp=0", tag_o); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
`ifdef MUL_PERF_CNT_EN
        checks++; if (perf_mul_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", perf_mul_cnt_o); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
        logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000002,
                                  32'h00000007, 32'h00000007, 32'h00000002, 32'hFFFFFFFF};
        logic [31:0] t_r  [8] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00000001, 32'h80000000};
        int lat;
        out_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid_i = 1'b1; op_i = t_op[k]; a_i = t_a[k]; b_i = t_b[k]; tag_i = 6'(40 + k);
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!out_valid_o && lat < 10) begin
                @(posedge clk); #1; lat++; @(negedge clk);
            end
            checks++; if (lat !== 3) begin failures++; $display("FAIL dir_latency case=%0d got=%0d exp=3", k, lat); end
            checks++; if (result_o !== t_r[k]) begin failures++; $display("FAIL dir_result case=%0d got=%h exp=%h", k, result_o, t_r[k]); end
            checks++; if (tag_o !== 6'(40 + k)) begin failures++; $display("FAIL dir_tag case=%0d got=%0d exp=%0d", k, tag_o, 40 + k); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int delivered = 0;
        int first = -1;
        int last = -1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 40 && delivered < 20; c++) begin
            if (c < 20) drive_random(6'(c));
            else in_valid_i = 1'b0;
            @(negedge clk);
            if (out_valid_o) begin
                checks++;
                if (exp_q.size() == 0 || {result_o, tag_o} !== exp_q[0]) begin
                    failures++; $display("FAIL b2b_data cyc=%0d got=%h/%0d exp=%h", c, result_o, tag_o, exp_q.size() ? exp_q[0] : '0);
                end
                if (first < 0) first = c;
                last = c;
                delivered++;
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        checks++; if (delivered !== 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", delivered); end
        checks++; if (first !== 3) begin failures++; $display("FAIL b2b_first got=%0d exp=3", first); end
        checks++; if (last !== 22) begin failures++; $display("FAIL b2b_last got=%0d exp=22", last); end
    endtask

    task automatic test_backpressure();
        logic [1:0]  ops [5];
        logic [31:0] as [5];
        logic [31:0] bs [5];
        logic [31:0] held_res = '0;
        logic [5:0]  held_tag = '0;
        bit held = 1'b0;
        bit acc;
        int k = 0;
        int delivered = 0;
        for (int i = 0; i < 5; i++) begin
            ops[i] = 2'($urandom_range(3, 0)); as[i] = $urandom; bs[i] = $urandom;
        end
        out_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid_i = (k < 5); op_i = ops[k % 5]; a_i = as[k % 5]; b_i = bs[k % 5]; tag_i = 6'(20 + k);
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            if (out_valid_o && !held) begin
                held = 1'b1; held_res = result_o; held_tag = tag_o;
            end else if (out_valid_o) begin
                checks++;
                if (result_o !== held_res || tag_o !== held_tag) begin
                    failures++; $display("FAIL bp_stable got=%h/%0d exp=%h/%0d", result_o, tag_o, held_res, held_tag);
                end
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        @(negedge clk);
        checks++; if (k !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", k); end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", in_ready_o); end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 30 && delivered < 5; c++) begin
            in_valid_i = (k < 5); op_i = ops[k % 5]; a_i = as[k % 5]; b_i = bs[k % 5]; tag_i = 6'(20 + k);
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            if (out_valid_o) begin
                checks++;
                if (exp_q.size() == 0 || {result_o, tag_o} !== exp_q[0]) begin
                    failures++; $display("FAIL bp_data got=%h/%0d exp=%h", result_o, tag_o, exp_q.size() ? exp_q[0] : '0);
                end
                delivered++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid_i = 1'b0;
        checks++; if (delivered !== 5) begin failures++; $display("FAIL bp_delivered got=%0d exp=5", delivered); end
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", out_valid_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] exp_r;
        int lat;
        out_ready_i = 1'b1;
        drive_random(6'd50);
        @(posedge clk); #1;
        drive_random(6'd51);
        @(posedge clk); #1;
        drive_random(6'd52);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_killed cyc=%0d got=%b exp=0", c, out_valid_o); end
            @(posedge clk); #1;
        end
        drive_random(6'd53);
        exp_r = ref_mul(op_i, a_i, b_i);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid_o && lat < 10) begin
            @(posedge clk); #1; lat++; @(negedge clk);
        end
        checks++; if (lat !== 3) begin failures++; $display("FAIL flush_next_latency got=%0d exp=3", lat); end
        checks++; if (result_o !== exp_r || tag_o !== 6'd53) begin
            failures++; $display("FAIL flush_next_data got=%h/%0d exp=%h/53", result_o, tag_o, exp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        int delivered = 0;
        int k = 0;
        bit acc;
        out_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_random(6'(c));
            if (c < 3) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid_o); end
        #2;
        rst = 1'b1; in_valid_i = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid_o); end
        checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL rst_async_result got=%h exp=0", result_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
`ifdef MUL_PERF_CNT_EN
        checks++; if (perf_mul_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_perf_zero got=%0d exp=0", perf_mul_cnt_o); end
`endif
        @(posedge clk); #1;
        for (int c = 0; c < 20 && delivered < 4; c++) begin
            if (k < 4) drive_random(6'(30 + k));
            else in_valid_i = 1'b0;
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            if (out_valid_o) begin
                checks++;
                if (exp_q.size() == 0 || {result_o, tag_o} !== exp_q[0]) begin
                    failures++; $display("FAIL rst_post_data got=%h/%0d exp=%h", result_o, tag_o, exp_q.size() ? exp_q[0] : '0);
                end
                delivered++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid_i = 1'b0;
        checks++; if (delivered !== 4) begin failures++; $display("FAIL rst_post_count got=%0d exp=4", delivered); end
`ifdef MUL_PERF_CNT_EN
        checks++; if (perf_mul_cnt_o !== 32'd4) begin failures++; $display("FAIL rst_perf_four got=%0d exp=4", perf_mul_cnt_o); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
